// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, decode control and IF/ID outputs.
// Latency: none, this is only wiring.
// Backpressure: stall travels from decode to fetch on this bundle.
interface fetch_stage_if #(
  parameter int N = 16
);
  logic [N-1:0] PC;
  logic [N-1:0] Instruction;
  logic         stall;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] if_id_instr;
  logic [N-1:0] if_id_pc;
  logic         if_id_valid;
  logic         halted;

  // Fetch stage side
  modport master (
    output PC, if_id_instr, if_id_pc, if_id_valid, halted,
    input  Instruction, stall, redirect, redirect_pc
  );

  // Memory / decode side
  modport slave (
    input  PC, if_id_instr, if_id_pc, if_id_valid, halted,
    output Instruction, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register plus IF/ID register, halt detection, redirect flush.
// Latency: instruction at PC lands in IF/ID one cycle later; redirect costs one bubble.
// Backpressure: stall freezes PC, IF/ID and state; redirect overrides stall.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / flush_count outputs.
module fetch_stage #(
  parameter int             N           = 16,
  parameter int             eff         = 10,
  parameter logic [N-1:0]   RESET_PC    = '0,
  parameter logic [N-1:0]   HALT_OPCODE = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]          fetch_count,
  output logic [31:0]          flush_count,
`endif
  fetch_stage_if.master        bus
);

  // Memory only sees the low eff bits of PC; it can never be wider than PC itself.
  if (eff > N) begin : g_bad_eff
    $error("fetch_stage: eff must not exceed N");
  end

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_pc, w_pc_nxt;
  logic [N-1:0] r_instr, w_instr_nxt;
  logic [N-1:0] r_ipc, w_ipc_nxt;
  logic         r_valid, w_valid_nxt;
  logic         w_load;

  // Next-state and next-register values; redirect beats stall, stall beats normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    if (bus.redirect) begin
      // Squashes whatever was fetched behind the branch, including a younger halt.
      w_state_nxt = ST_RUN;
      w_pc_nxt    = bus.redirect_pc;
      w_instr_nxt = '0;
      w_ipc_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else if (!bus.stall) begin
      if (r_state == ST_RUN) begin
        w_load      = 1'b1;
        w_instr_nxt = bus.Instruction;
        w_ipc_nxt   = r_pc;
        w_valid_nxt = 1'b1;
        if (bus.Instruction == HALT_OPCODE) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt = r_pc + N'(1);
        end
      end else begin
        // Halted: keep emitting bubbles, PC parked on the halt instruction.
        w_instr_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_ipc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.PC          = r_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc    = r_ipc;
  assign bus.if_id_valid = r_valid;
  assign bus.halted      = (r_state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  // Saturating event counters: real fetches into IF/ID and redirect flushes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (bus.redirect && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset traffic.
// Latency: compares every output one step after each rising edge.
// Backpressure: stall and redirect are driven randomly against a reference model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [15:0] mem [1024];

  fetch_stage_if #(.N(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  fetch_stage #(
    .N(16), .eff(10), .RESET_PC(16'h0000), .HALT_OPCODE(16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .flush_count (flush_count),
`endif
    .bus         (bus)
  );

  // Combinational instruction memory indexed by the low 10 PC bits.
  assign bus.Instruction = mem[bus.PC[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what a fetch stage should show after each edge.
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halt;
  logic [31:0] m_fc, m_flc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit rd, input logic [15:0] rpc);
    logic [15:0] cur;
    @(negedge clk);
    rst_n           = rn;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    cur = mem[m_pc[9:0]];
    if (!rn) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_valid = 1'b0; m_halt = 1'b0; m_fc = 0; m_flc = 0;
    end else if (rd) begin
      m_pc = rpc; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_valid = 1'b0; m_halt = 1'b0;
      if (m_flc != 32'hFFFF_FFFF) m_flc = m_flc + 1;
    end else if (!st) begin
      if (m_halt) begin
        m_valid = 1'b0; m_instr = 16'h0000;
      end else begin
        m_instr = cur; m_ipc = m_pc; m_valid = 1'b1;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        if (cur == 16'hFFFF) m_halt = 1'b1;
        else                 m_pc = m_pc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    check("pc",     {16'h0, bus.PC},          {16'h0, m_pc});
    check("instr",  {16'h0, bus.if_id_instr}, {16'h0, m_instr});
    check("ipc",    {16'h0, bus.if_id_pc},    {16'h0, m_ipc});
    check("valid",  {31'h0, bus.if_id_valid}, {31'h0, m_valid});
    check("halted", {31'h0, bus.halted},      {31'h0, m_halt});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_fc);
    check("flush_count", flush_count, m_flc);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halt = 0; m_fc = 0; m_flc = 0;

    // Random program with occasional halts, then pin the directed locations.
    for (int i = 0; i < 1024; i++) begin
      mem[i] = ($urandom_range(0, 99) < 3) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
    end
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hFFFF;
    for (int i = 4; i <= 8; i++) mem[i] = 16'h2000 + 16'(i);
    for (int i = 16; i <= 18; i++) mem[i] = 16'h3000 + 16'(i);
    mem[16'h40] = 16'h4040; mem[16'h41] = 16'h4041;
    mem[10'h3FF] = 16'h53FF;

    // Reset, then straight-line fetch into the halt at location 3 and bubbles.
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    repeat (6) step(1, 0, 0, 16'h0);
    // Redirect out of HALT to 0x10.
    step(1, 0, 1, 16'h0010);
    repeat (2) step(1, 0, 0, 16'h0);
    // Load a valid instruction at PC 4, then stall three cycles at PC 5.
    step(1, 0, 1, 16'h0004);
    step(1, 0, 0, 16'h0);
    repeat (3) step(1, 1, 0, 16'h0);
    repeat (2) step(1, 0, 0, 16'h0);
    // Redirect wins over stall.
    step(1, 0, 1, 16'h0007);
    step(1, 1, 1, 16'h0040);
    repeat (2) step(1, 0, 0, 16'h0);
    // PC wrap from FFFF to 0000.
    step(1, 0, 1, 16'hFFFF);
    repeat (2) step(1, 0, 0, 16'h0);
    // Reset beats simultaneous stall and redirect; then 3 fetches and 1 redirect.
    step(0, 1, 1, 16'h0123);
    repeat (3) step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0200);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit          rn, st, rd;
      logic [15:0] rpc;
      rn  = ($urandom_range(0, 199) != 0);
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) < 2);
      rpc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : 16'($urandom_range(0, 16'hFFFF));
      step(rn, st, rd, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
